// File: rtl/gpio_example_system.sv
// gpio_example_system: a self-contained GPIO demo. An internal AXI4-Lite master
// polls the synchronized push buttons through an internal AXI4-Lite GPIO slave.
// It maps each button code to an LED pattern and writes that pattern back to
// the slave's DATA_OUT register. The LEDs show DATA_OUT gated by DIR.
module gpio_example_system #(
    parameter int SYS_CLK_FREQ = 100_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_resetn,
    input  logic [3:0]  buttons,
    output logic [7:0]  leds,
    output logic [31:0] axi_debug_data,
    output logic        axi_debug_valid
);

    // One poll every 10 us. The clamp keeps tiny clock values from giving a zero-length poll.
    localparam int POLL_CYCLES = (SYS_CLK_FREQ / 100_000 > 1) ? SYS_CLK_FREQ / 100_000 : 1;
    localparam int TIMER_W     = $clog2(POLL_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_CYCLES - 1);

    // Slave register map.
    localparam logic [3:0] ADDR_DATA_OUT = 4'h0;
    localparam logic [3:0] ADDR_DATA_IN  = 4'h4;
    localparam logic [3:0] ADDR_DIR      = 4'h8;
    localparam logic [1:0] RESP_OKAY     = 2'b00;

    // Master FSM states.
    localparam logic [1:0] ST_INIT_WR_DIR = 2'd0;
    localparam logic [1:0] ST_IDLE        = 2'd1;
    localparam logic [1:0] ST_RD_IN       = 2'd2;
    localparam logic [1:0] ST_WR_OUT      = 2'd3;

    // Internal AXI4-Lite bus. The master drives AW and W with a single shared valid.
    logic [3:0]  awaddr;
    logic        wr_valid;
    logic        awready;
    logic        wready;
    logic [31:0] wdata;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;

    // Slave state.
    logic [3:0]  btn_meta;
    logic [3:0]  btn_sync;
    logic [7:0]  data_out_q;
    logic [7:0]  dir_q;
    logic [31:0] rd_mux;

    // Master state.
    logic [1:0]         state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [3:0]         awaddr_q;
    logic [31:0]        wdata_q;
    logic               wr_valid_q;
    logic               bready_q;
    logic               arvalid_q;
    logic               rready_q;
    logic [7:0]         pattern_q;

    // Button-code to LED-pattern translation.
    function automatic logic [7:0] map_pattern(input logic [3:0] b);
        logic [7:0] p;
        case (b)
            4'b0000: p = 8'h00;
            4'b0001: p = 8'h01;
            4'b0010: p = 8'h03;
            4'b0100: p = 8'h0F;
            4'b1000: p = 8'hFF;
            4'b0011: p = 8'hAA;
            4'b1100: p = 8'hF0;
            default: p = {b, b};
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------ slave

    // Two-flop synchronizer for the asynchronous button levels.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= buttons;
            btn_sync <= btn_meta;
        end
    end

    // Write channel. AWREADY/WREADY pulse once both valids are present.
    // The register update and BVALID follow on the accepting edge.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            data_out_q <= '0;
            dir_q      <= '0;
        end else begin
            if (awready) begin
                awready <= 1'b0;
                wready  <= 1'b0;
                bvalid  <= 1'b1;
                case (awaddr)
                    ADDR_DATA_OUT: data_out_q <= wdata[7:0];
                    ADDR_DIR:      dir_q      <= wdata[7:0];
                    default:       ;  // unmapped or read-only: ignored, still OKAY
                endcase
            end else if (wr_valid && !bvalid) begin
                awready <= 1'b1;
                wready  <= 1'b1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read data decode. Unmapped addresses read as zero.
    // NOTE: the default assignment on the first line keeps this block free of inferred latches.
    always_comb begin
        rd_mux = '0;
        case (araddr)
            ADDR_DATA_OUT: rd_mux = {24'h0, data_out_q};
            ADDR_DATA_IN:  rd_mux = {28'h0, btn_sync};
            ADDR_DIR:      rd_mux = {24'h0, dir_q};
            default:       rd_mux = '0;
        endcase
    end

    // Read channel. ARREADY pulses one cycle after ARVALID, then RVALID is held until RREADY.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            if (arready) begin
                arready <= 1'b0;
                rvalid  <= 1'b1;
                rdata   <= rd_mux;
            end else if (arvalid && !rvalid) begin
                arready <= 1'b1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign bresp = RESP_OKAY;
    assign rresp = RESP_OKAY;
    assign leds  = data_out_q & dir_q;

    // ----------------------------------------------------------------- master

    // Poll sequencer: configure DIR once, then alternate between timed DATA_IN reads and DATA_OUT writes.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q         <= ST_INIT_WR_DIR;
            timer_q         <= '0;
            awaddr_q        <= '0;
            wdata_q         <= '0;
            wr_valid_q      <= 1'b0;
            bready_q        <= 1'b0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            pattern_q       <= '0;
            axi_debug_data  <= '0;
            axi_debug_valid <= 1'b0;
        end else begin
            axi_debug_valid <= 1'b0;
            case (state_q)
                ST_INIT_WR_DIR, ST_WR_OUT: begin
                    if (!wr_valid_q && !bready_q) begin
                        wr_valid_q <= 1'b1;
                        if (state_q == ST_INIT_WR_DIR) begin
                            awaddr_q <= ADDR_DIR;
                            wdata_q  <= 32'h0000_00FF;
                        end else begin
                            awaddr_q <= ADDR_DATA_OUT;
                            wdata_q  <= {24'h0, pattern_q};
                        end
                    end
                    if (wr_valid_q && awready) begin
                        wr_valid_q <= 1'b0;
                        bready_q   <= 1'b1;
                    end
                    if (bready_q && bvalid) begin
                        bready_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (timer_q == TIMER_LAST) begin
                        state_q <= ST_RD_IN;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin  // ST_RD_IN
                    if (!arvalid_q && !rready_q) begin
                        arvalid_q <= 1'b1;
                    end
                    if (arvalid_q && arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                    if (rready_q && rvalid) begin
                        rready_q        <= 1'b0;
                        axi_debug_data  <= rdata;
                        axi_debug_valid <= 1'b1;
                        pattern_q       <= map_pattern(rdata[3:0]);
                        state_q         <= ST_WR_OUT;
                    end
                end
            endcase
        end
    end

    assign awaddr   = awaddr_q;
    assign wdata    = wdata_q;
    assign wr_valid = wr_valid_q;
    assign bready   = bready_q;
    assign araddr   = ADDR_DATA_IN;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;

    // Bus fields that the fixed-function master and the 8-bit registers never consume.
    logic unused_bus;
    assign unused_bus = ^{wdata[31:8], wready, bresp, rresp};

endmodule

// File: tb/tb_gpio_example_system.sv
`timescale 1ns/1ps
// Bench for gpio_example_system. It runs at a 10 MHz clock, so one poll is
// 100 cycles and real microsecond timings hold.
// Expected responses are queued when stimulus is applied. A monitor pops and
// compares them on each axi_debug_valid pulse.
module tb_gpio_example_system;

    localparam int CLK_FREQ = 10_000_000;
    localparam int POLL     = CLK_FREQ / 100_000;  // cycles per 10 us

    logic        sys_clk = 1'b0;
    logic        sys_resetn;
    logic [3:0]  buttons;
    logic [7:0]  leds;
    logic [31:0] axi_debug_data;
    logic        axi_debug_valid;

    gpio_example_system #(.SYS_CLK_FREQ(CLK_FREQ)) dut (
        .sys_clk        (sys_clk),
        .sys_resetn     (sys_resetn),
        .buttons        (buttons),
        .leds           (leds),
        .axi_debug_data (axi_debug_data),
        .axi_debug_valid(axi_debug_valid)
    );

    always #50 sys_clk = ~sys_clk;

    typedef struct {
        string       name;
        logic [7:0]  leds;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_pulses = 0;

    // Hand-derived expected LED pattern for each button code 0..15.
    logic [7:0] led_tab [16] = '{8'h00, 8'h01, 8'h03, 8'hAA, 8'h0F, 8'h55, 8'h66, 8'h77,
                                 8'hFF, 8'h99, 8'hAA, 8'hBB, 8'hF0, 8'hDD, 8'hEE, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Drive a button code and let at least two polls pass.
    // Then queue the response the next poll must give, and hold for the rest of the interval.
    task automatic apply(input string name, input logic [3:0] b, input int hold_cycles);
        exp_t e;
        buttons = b;
        wait_cycles(250);
        e.name = name;
        e.leds = led_tab[b];
        e.data = {28'h0, b};
        exp_q.push_back(e);
        wait_cycles(hold_cycles - 250);
    endtask

    // Bounded wait for leds to reach a value; an expired budget shows up as a failed check.
    task automatic expect_leds_within(input string name, input logic [7:0] exp, input int budget);
        int k = 0;
        while (leds !== exp && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check(name, leds, exp);
    endtask

    // Monitor: checks pulse width and poll spacing, and scoreboard entries against each poll.
    initial begin
        int   cyc  = 0;
        int   last = -1;
        exp_t e;
        forever begin
            @(posedge sys_clk); #1; cyc++;
            if (!sys_resetn) begin
                last = -1;
            end else if (axi_debug_valid) begin
                n_pulses++;
                if (last >= 0)
                    check("poll_interval_ok", 32'((cyc - last >= POLL) && (cyc - last <= POLL + 30)), 32'd1);
                last = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({e.name, "_data"}, axi_debug_data, e.data);
                    @(posedge sys_clk); #1; cyc++;
                    check("debug_valid_width", 32'(axi_debug_valid), 32'd0);
                    repeat (9) begin @(posedge sys_clk); #1; cyc++; end
                    check({e.name, "_leds"}, 32'(leds), 32'(e.leds));
                end else begin
                    @(posedge sys_clk); #1; cyc++;
                    check("debug_valid_width", 32'(axi_debug_valid), 32'd0);
                end
            end
        end
    end

    // Watchdog: the directed run is about 1.4 ms.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        logic [3:0] b;
        int         found;

        // Reset for 1 us with buttons released.
        buttons    = 4'b0000;
        sys_resetn = 1'b0;
        wait_cycles(10);
        check("rst_leds", 32'(leds), 32'h00);
        check("rst_debug_valid", 32'(axi_debug_valid), 32'd0);
        check("rst_debug_data", axi_debug_data, 32'h0);
        check("rst_dir", 32'(dut.dir_q), 32'h00);
        check("rst_state", 32'(dut.state_q), 32'd0);
        sys_resetn = 1'b1;

        // Idle run for 50 us: DIR configured, polls running, nothing lit.
        wait_cycles(500);
        check("idle_leds", 32'(leds), 32'h00);
        check("idle_dir", 32'(dut.dir_q), 32'hFF);
        check("idle_pulses_ge4", 32'(n_pulses >= 4), 32'd1);
        check("idle_debug_data", axi_debug_data, 32'h0);

        // Single-button patterns, 100 us each.
        apply("b0001", 4'b0001, 1000);
        apply("b0010", 4'b0010, 1000);
        apply("b0100", 4'b0100, 1000);
        apply("b1000", 4'b1000, 1000);

        // Two-button special patterns and release.
        apply("b0011", 4'b0011, 1000);
        apply("b1100", 4'b1100, 1000);
        apply("b0000", 4'b0000, 1000);

        // Latency: fall-through codes must reach leds within one poll plus margin.
        buttons = 4'b0101;
        expect_leds_within("lat_0101", 8'h55, POLL + 20);
        wait_cycles(200);
        buttons = 4'b1111;
        expect_leds_within("lat_1111", 8'hFF, POLL + 20);
        wait_cycles(200);

        // Random codes at 50 us intervals.
        for (int i = 0; i < 10; i++) begin
            b = 4'($urandom_range(0, 15));
            apply($sformatf("rand%0d_b%0h", i, b), b, 500);
        end

        // Reset in the middle of a DATA_OUT write with buttons = 1000.
        buttons = 4'b1000;
        wait_cycles(250);
        found = 0;
        for (int k = 0; k < 3 * POLL && found == 0; k++) begin
            @(negedge sys_clk);
            if (dut.state_q == 2'd3) found = 1;
        end
        check("reach_wr_out", 32'(found), 32'd1);
        check("pre_reset_leds", 32'(leds), 32'hFF);
        sys_resetn = 1'b0;
        #1;
        check("midtx_reset_leds", 32'(leds), 32'h00);
        check("midtx_reset_state", 32'(dut.state_q), 32'd0);
        wait_cycles(10);
        sys_resetn = 1'b1;
        expect_leds_within("post_reset_leds", 8'hFF, POLL + 30);

        // Give the monitor time to consume anything still queued.
        wait_cycles(300);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
